// File: rtl/data_mem_responder_if.sv
// Bus between a load/store unit and the data memory responder.
// The master issues accesses and fault clears; the slave returns load data and status.
interface data_mem_responder_if;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_WR_out;
    logic [2:0]  MEM_type;
    logic        MEM_rd_en;
    logic        MEM_wr_en;
    logic [31:0] MEM_data;
    logic        fault_clr;
    logic        fault;
    logic [31:0] fault_addr;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport master (
        output MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en, fault_clr,
        input  MEM_data, fault, fault_addr, rd_count, wr_count
    );

    modport slave (
        input  MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en, fault_clr,
        output MEM_data, fault, fault_addr, rd_count, wr_count
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte/half/word access, zero-latency loads,
// byte-enabled stores, a sticky access-fault record and load/store counters.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input logic                 CLK,
    input logic                 Reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] T_BYTE  = 3'b000;
    localparam logic [2:0] T_HALF  = 3'b001;
    localparam logic [2:0] T_WORD  = 3'b010;
    localparam logic [2:0] T_BYTEU = 3'b100;
    localparam logic [2:0] T_HALFU = 3'b101;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          fault_q,      fault_d;
    logic [31:0]   fault_addr_q, fault_addr_d;
    logic [15:0]   rd_count_q,   rd_count_d;
    logic [15:0]   wr_count_q,   wr_count_d;

    logic          is_byte, is_half, is_word;
    logic          misaligned, out_of_range, fault_now;
    logic          load_ok, store_ok;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   rd_data;

    assign idx  = bus.MEM_addr[AW+1:2];
    assign lane = bus.MEM_addr[1:0];

    // Access decode and fault detection
    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        is_byte      = 1'b0;
        is_half      = 1'b0;
        is_word      = 1'b0;
        case (bus.MEM_type)
            T_BYTE, T_BYTEU: is_byte = 1'b1;
            T_HALF, T_HALFU: is_half = 1'b1;
            T_WORD:          is_word = 1'b1;
            default:         ;
        endcase
        misaligned   = (is_half && lane[0]) || (is_word && (lane != 2'b00));
        out_of_range = |bus.MEM_addr[31:AW+2];
        fault_now    = (bus.MEM_rd_en || bus.MEM_wr_en) &&
                       (!(is_byte || is_half || is_word) || misaligned || out_of_range ||
                        (bus.MEM_rd_en && bus.MEM_wr_en));
        load_ok      = bus.MEM_rd_en && !fault_now;
        store_ok     = bus.MEM_wr_en && !fault_now;
    end

    // Store lane steering: narrow data is replicated so each enabled lane picks its own copy
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = bus.MEM_WR_out;
        if (is_byte) begin
            byte_en  = 4'b0001 << lane;
            wr_lanes = {4{bus.MEM_WR_out[7:0]}};
        end else if (is_half) begin
            byte_en  = lane[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{bus.MEM_WR_out[15:0]}};
        end else if (is_word) begin
            byte_en  = 4'b1111;
        end
    end

    // NOTE: storage is deliberately left out of reset; only the control state is reset.
    always_ff @(posedge CLK) begin
        if (store_ok && !Reset) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    assign rd_word = mem_q[idx];

    always_comb begin
        rd_data = 32'h0;
        if (load_ok) begin
            if (is_byte)      rd_data = {24'h0, rd_word[{lane, 3'b000} +: 8]};
            else if (is_half) rd_data = {16'h0, rd_word[{lane[1], 4'b0000} +: 16]};
            else              rd_data = rd_word;
        end
    end

    // A new fault outranks a coincident clear and re-captures the address
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (fault_now && (!fault_q || bus.fault_clr)) begin
            fault_d      = 1'b1;
            fault_addr_d = bus.MEM_addr;
        end else if (bus.fault_clr) begin
            fault_d      = 1'b0;
        end
        rd_count_d = rd_count_q + {15'h0, load_ok};
        wr_count_d = wr_count_q + {15'h0, store_ok};
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            rd_count_q   <= 16'h0;
            wr_count_q   <= 16'h0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign bus.MEM_data   = rd_data;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;
    assign bus.rd_count   = rd_count_q;
    assign bus.wr_count   = wr_count_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: each load pushes its expected data and
// status snapshot; a monitor pops and compares whenever a load is presented.
module tb_data_mem_responder;
    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH_WORDS(1024)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        f;
        logic [31:0] fa;
        logic [15:0] rdc;
        logic [15:0] wrc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] typ, input logic [31:0] wdata, input logic clr);
        bus.MEM_rd_en  = rd;
        bus.MEM_wr_en  = wr;
        bus.MEM_addr   = addr;
        bus.MEM_type   = typ;
        bus.MEM_WR_out = wdata;
        bus.fault_clr  = clr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, T_B, 32'h0, 1'b0);
        tick();
    endtask

    task automatic st(input logic [31:0] addr, input logic [2:0] typ,
                      input logic [31:0] wdata, input logic clr);
        drive(1'b0, 1'b1, addr, typ, wdata, clr);
        tick();
    endtask

    // Expected status is the state before this cycle's edge
    task automatic ld(input string name, input logic [31:0] addr, input logic [2:0] typ,
                      input logic clr, input logic [31:0] d, input logic f,
                      input logic [31:0] fa, input logic [15:0] rdc, input logic [15:0] wrc);
        exp_q.push_back(exp_t'{name, d, f, fa, rdc, wrc});
        drive(1'b1, 1'b0, addr, typ, 32'h0, clr);
        tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.MEM_rd_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_entry", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, ".data"},       bus.MEM_data,            e.data);
                    check({e.name, ".fault"},      {31'h0, bus.fault},      {31'h0, e.f});
                    check({e.name, ".fault_addr"}, bus.fault_addr,          e.fa);
                    check({e.name, ".rd_count"},   {16'h0, bus.rd_count},   {16'h0, e.rdc});
                    check({e.name, ".wr_count"},   {16'h0, bus.wr_count},   {16'h0, e.wrc});
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        drive(1'b0, 1'b0, 32'h0, T_B, 32'h0, 1'b0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        st(32'h0000_0000, T_W, 32'h1122_3344, 1'b0);
        st(32'h0000_0010, T_W, 32'hDEAD_BEEF, 1'b0);
        ld("word_ld",     32'h10, T_W, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 16'd0, 16'd2);
        st(32'h0000_0011, T_B, 32'h1234_56AA, 1'b0);
        ld("byte_ld",     32'h11, T_B,  1'b0, 32'h0000_00AA, 1'b0, 32'h0, 16'd1, 16'd3);
        ld("merged_word", 32'h10, T_W,  1'b0, 32'hDEAD_AAEF, 1'b0, 32'h0, 16'd2, 16'd3);
        ld("half_hi",     32'h12, T_H,  1'b0, 32'h0000_DEAD, 1'b0, 32'h0, 16'd3, 16'd3);
        ld("byteu_lane3", 32'h13, T_BU, 1'b0, 32'h0000_00DE, 1'b0, 32'h0, 16'd4, 16'd3);
        ld("word_misal",  32'h12, T_W,  1'b0, 32'h0,         1'b0, 32'h0, 16'd5, 16'd3);
        st(32'h0000_4000, T_W, 32'hCAFE_F00D, 1'b0);
        ld("after_oor_st", 32'h10, T_W, 1'b0, 32'hDEAD_AAEF, 1'b1, 32'h12, 16'd5, 16'd3);
        ld("word0_intact", 32'h00, T_W, 1'b0, 32'h1122_3344, 1'b1, 32'h12, 16'd6, 16'd3);
        ld("clr_vs_fault", 32'h20, 3'b011, 1'b1, 32'h0,      1'b1, 32'h12, 16'd7, 16'd3);
        ld("clr_halfu",    32'h10, T_HU, 1'b1, 32'h0000_AAEF, 1'b1, 32'h20, 16'd7, 16'd3);
        ld("half_odd",     32'h11, T_H,  1'b0, 32'h0,         1'b0, 32'h20, 16'd8, 16'd3);
        ld("clr_word",     32'h10, T_W,  1'b1, 32'hDEAD_AAEF, 1'b1, 32'h11, 16'd8, 16'd3);

        exp_q.push_back(exp_t'{"both_en", 32'h0, 1'b0, 32'h11, 16'd9, 16'd3});
        drive(1'b1, 1'b1, 32'h10, T_W, 32'h1234_5678, 1'b0);
        tick();
        ld("after_both",   32'h10, T_W, 1'b0, 32'hDEAD_AAEF, 1'b1, 32'h10, 16'd9, 16'd3);
        st(32'h0000_0014, 3'b111, 32'h0, 1'b1);
        ld("illegal_st",   32'h10, T_W, 1'b0, 32'hDEAD_AAEF, 1'b1, 32'h14, 16'd10, 16'd3);
        st(32'h0000_0FFF, T_B, 32'h0000_005A, 1'b1);
        ld("last_byte",    32'hFFF, T_B, 1'b0, 32'h0000_005A, 1'b0, 32'h14, 16'd11, 16'd4);
        ld("first_oor",    32'h1000, T_B, 1'b0, 32'h0,        1'b0, 32'h14, 16'd12, 16'd4);
        ld("high_addr",    32'h8000_0010, T_B, 1'b1, 32'h0,   1'b1, 32'h1000, 16'd12, 16'd4);
        st(32'h0000_0012, T_H, 32'hFFFF_BEEF, 1'b1);
        ld("half_st",      32'h10, T_W, 1'b0, 32'hBEEF_AAEF, 1'b0, 32'h8000_0010, 16'd12, 16'd5);
        idle();
        ld("after_idle",   32'h10, T_W, 1'b0, 32'hBEEF_AAEF, 1'b0, 32'h8000_0010, 16'd13, 16'd5);
        ld("pre_reset",    32'h11, T_W, 1'b0, 32'h0,         1'b0, 32'h8000_0010, 16'd14, 16'd5);

        // Reset lands mid-cycle while a load is in flight
        exp_q.push_back(exp_t'{"rst_async", 32'hBEEF_AAEF, 1'b0, 32'h0, 16'd0, 16'd0});
        drive(1'b1, 1'b0, 32'h10, T_W, 32'h0, 1'b0);
        #1 Reset = 1'b1;
        tick();
        st(32'h0000_0010, T_W, 32'h5555_5555, 1'b0);
        ld("rst_hold",     32'h10, T_W, 1'b0, 32'hBEEF_AAEF, 1'b0, 32'h0, 16'd0, 16'd0);
        drive(1'b0, 1'b0, 32'h0, T_B, 32'h0, 1'b0);
        Reset = 1'b0;
        tick();
        st(32'h0000_0010, T_W, 32'h0BAD_F00D, 1'b0);
        ld("st_then_ld",   32'h10, T_W, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0, 16'd0, 16'd1);

        // Store counter wrap from a fresh reset
        drive(1'b0, 1'b0, 32'h0, T_B, 32'h0, 1'b0);
        Reset = 1'b1;
        #2 Reset = 1'b0;
        tick();
        for (int i = 0; i < 65535; i++) st(32'h20, T_W, 32'(i), 1'b0);
        ld("wr_ffff",      32'h20, T_W, 1'b0, 32'h0000_FFFE, 1'b0, 32'h0, 16'd0, 16'hFFFF);
        st(32'h20, T_W, 32'hA5A5_A5A5, 1'b0);
        ld("wr_wrap",      32'h20, T_W, 1'b0, 32'hA5A5_A5A5, 1'b0, 32'h0, 16'd1, 16'h0000);

        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words (power of two, 16..4096).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port MEM_addr  input  32  byte address of current access.
REQ-005 SHALL have port MEM_WR_out  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-006 SHALL have port MEM_type  input  3  transfer size/kind, RISC-V funct3 encoding.
REQ-007 SHALL have port MEM_rd_en  input  1  load request this cycle.
REQ-008 SHALL have port MEM_wr_en  input  1  store request this cycle.
REQ-009 SHALL have port MEM_data  output  32  load data, right-justified, zero-extended.
REQ-010 SHALL have port fault_clr  input  1  synchronous clear of sticky fault state.
REQ-011 SHALL have port fault  output  1  sticky access-fault flag.
REQ-012 SHALL have port fault_addr  output  32  MEM_addr of first fault since last clear.
REQ-013 SHALL have port rd_count  output  16  count of completed loads.
REQ-014 SHALL have port wr_count  output  16  count of completed stores.

Function
REQ-015 MEM_type decode SHALL be: 000/100 byte, 001/101 half, 010 word; 011, 110, 111 illegal.
REQ-016 Word index SHALL be MEM_addr[log2(DEPTH_WORDS)+1:2]; lane SHALL be MEM_addr[1:0].
REQ-017 An access SHALL fault if: type illegal; half with addr[0]=1; word with addr[1:0]!=00; MEM_addr >= 4*DEPTH_WORDS; or MEM_rd_en and MEM_wr_en both high.
REQ-018 Loads SHALL be combinational (zero-cycle latency): MEM_data valid in same cycle MEM_rd_en is high, reflecting storage as of the last clock edge.
REQ-019 Byte load SHALL return selected lane in [7:0], upper 24 bits zero; half load SHALL return lanes {addr[1]*2+1, addr[1]*2} in [15:0], upper 16 bits zero; word load SHALL return full word.
REQ-020 MEM_data SHALL be 32'h0 when MEM_rd_en is low or the access faults.
REQ-021 Stores SHALL commit at the rising edge with byte enables: byte -> one lane from MEM_WR_out[7:0]; half -> two lanes from MEM_WR_out[15:0]; word -> all four lanes; unselected lanes unchanged.
REQ-022 A faulting store SHALL not modify storage.
REQ-023 A store followed by a load of the same address next cycle SHALL return the newly written data.
REQ-024 On a faulting access with fault low, the edge SHALL set fault=1 and load fault_addr=MEM_addr; further faults SHALL not change fault_addr while fault=1.
REQ-025 fault_clr SHALL clear fault at the edge; if fault_clr coincides with a new fault, the new fault SHALL win (fault=1, fault_addr=new MEM_addr).
REQ-026 rd_count/wr_count SHALL increment by 1 per non-faulting load/store edge and wrap 16'hFFFF -> 16'h0000; faulting accesses SHALL not count.
REQ-027 Cycles with both enables low SHALL change no state.

Reset
REQ-028 Reset assertion SHALL immediately force fault=0, fault_addr=32'h0, rd_count=0, wr_count=0, independent of CLK.
REQ-029 Storage contents SHALL not be reset; stores presented while Reset is high SHALL be ignored.
REQ-030 MEM_data SHALL remain combinational per REQ-018..020 during reset (storage unchanged).
REQ-031 Reset asserted mid-sequence SHALL discard the in-flight edge's counter/fault update; storage keeps last committed value.

Verification
REQ-032 Word store 0xDEADBEEF @0x10, then word load @0x10 -> MEM_data=0xDEADBEEF, wr_count=1, rd_count=1.
REQ-033 Byte store 0xAA @0x11 over word 0xDEADBEEF, byte load @0x11 then word load @0x10 -> 0x000000AA then 0xDEADAAEF.
REQ-034 Half load @0x12 of 0xDEADAAEF -> 0x0000DEAD; word load @0x12 -> MEM_data=0, fault=1, fault_addr=0x12, rd_count unchanged.
REQ-035 With fault=1 at 0x12, word store @0x4000 (DEPTH_WORDS=1024) -> storage unchanged, fault_addr stays 0x12; fault_clr plus simultaneous type=011 load @0x20 -> fault=1, fault_addr=0x20.
REQ-036 Both MEM_rd_en and MEM_wr_en high, word @0x10, data 0x12345678 -> no write, MEM_data=0, fault=1; subsequent load @0x10 -> 0xDEADAAEF.
REQ-037 Preload wr_count=0xFFFF via 65535 stores, assert Reset asynchronously mid-cycle -> all counters/fault zero before next edge; one more store after release -> wr_count=1, and separately 65536 stores from reset -> wr_count wraps to 0x0000.
